// File: rtl/tl_phase_timer.sv
// Phase-duration timer: prescaled ticks count down a green/yellow phase and end it with a one-cycle done_pulse.
// Optional TL_TIMER_HOLD_EN adds a hold input that freezes counting while in RUN.
module tl_phase_timer #(
    parameter int CLK_DIV      = 10,
    parameter int GREEN_TICKS  = 30,
    parameter int YELLOW_TICKS = 5,
    parameter int CNT_W        = 8,
    parameter int DIV_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer_select,
`ifdef TL_TIMER_HOLD_EN
    input  logic             hold,
`endif
    output logic             done_pulse,
    output logic             tick,
    output logic [CNT_W-1:0] remaining
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS);

    if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || CLK_DIV < 1) begin : g_bad_min
        $error("tl_phase_timer: GREEN_TICKS, YELLOW_TICKS and CLK_DIV must be >= 1");
    end
    if ((GREEN_TICKS >> CNT_W) != 0 || (YELLOW_TICKS >> CNT_W) != 0 ||
        ((CLK_DIV - 1) >> DIV_W) != 0) begin : g_bad_width
        $error("tl_phase_timer: parameter value exceeds its counter width");
    end

    logic [1:0]       state;
    logic [DIV_W-1:0] prescaler;
    logic [CNT_W-1:0] count;
    logic             run_en;

`ifdef TL_TIMER_HOLD_EN
    assign run_en = ~hold;
`else
    assign run_en = 1'b1;
`endif

    assign done_pulse = (state == ST_DONE);
    assign tick       = (state == ST_RUN) && run_en && (prescaler == DIV_LAST);
    assign remaining  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_LOAD;
            prescaler <= '0;
            count     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    count     <= timer_select ? GREEN_LD : YELLOW_LD;
                    prescaler <= '0;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (run_en) begin
                        if (prescaler == DIV_LAST) begin
                            prescaler <= '0;
                            // count is always >= 1 here; the guard keeps it from ever wrapping
                            if (count != '0) begin
                                count <= count - 1'b1;
                            end
                            if (count == CNT_W'(1)) begin
                                state <= ST_DONE;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_LOAD;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
